// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS peripherals: UART TX register offsets,
// transmitter state encoding and STATUS register bit positions.
package otter_io_pkg;

  // Register offsets from the peripheral base address
  localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;
  localparam logic [31:0] UART_DIV_OFS  = 32'h0000_0008;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // STATUS register bit positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;

endpackage

// File: rtl/otter_iobus_uart_tx_if.sv
// OTTER IOBUS bundle as seen by one memory-mapped peripheral.
// Handshake: the bus has no ready. wr is a one-cycle store strobe qualified by
// addr/wdata in the same cycle and is always accepted; rdata is a
// combinational function of addr, valid in the cycle addr is presented.
interface otter_iobus_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wr, input  rdata);
  modport slave  (input  addr, input  wdata, input  wr, output rdata);
endinterface

// File: rtl/otter_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// A push while full is accepted only when a pop happens in the same cycle.
module otter_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end
endmodule

// File: rtl/otter_iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// Window: DATA (+0x0, push byte), STATUS (+0x4), DIVISOR (+0x8).
// Optional feature macro: OTTER_UART_TX_IRQ_EN enables a transmit-done IRQ
// pulse; without it IRQ is tied low.
module otter_iobus_uart_tx
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        IRQ
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  otter_iobus_uart_tx_if u_bus ();
  assign u_bus.addr  = IOBUS_ADDR;
  assign u_bus.wdata = IOBUS_OUT;
  assign u_bus.wr    = IOBUS_WR;
  assign IOBUS_IN    = u_bus.rdata;

  uart_tx_state_t r_state;
  logic [15:0]    r_div;
  logic [15:0]    r_div_lat;
  logic [15:0]    r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           r_ovf;

  logic             w_sel_data, w_sel_stat, w_sel_div;
  logic             w_wr_data, w_wr_stat, w_wr_div;
  logic             w_pop, w_full, w_empty, w_bit_end;
  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic [15:0]      w_div_eff;
  logic [31:0]      w_stat;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_sel_data = (u_bus.addr == BASE_ADDR + UART_DATA_OFS);
  assign w_sel_stat = (u_bus.addr == BASE_ADDR + UART_STAT_OFS);
  assign w_sel_div  = (u_bus.addr == BASE_ADDR + UART_DIV_OFS);
  assign w_wr_data  = u_bus.wr & w_sel_data;
  assign w_wr_stat  = u_bus.wr & w_sel_stat;
  assign w_wr_div   = u_bus.wr & w_sel_div;
  assign w_unused_wdata = ^u_bus.wdata[31:16];

  // A zero divisor would never end a bit period, so it behaves as 1
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_end = (r_baud == 16'd0);
  // Head is taken from IDLE, or straight from the end of STOP for back-to-back frames
  assign w_pop = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

  otter_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_wr_data),
    .i_din   (u_bus.wdata[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // DIVISOR register and sticky overflow flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= u_bus.wdata[15:0];
      if (w_wr_data && w_full && !w_pop)             r_ovf <= 1'b1;
      else if (w_wr_stat && u_bus.wdata[STAT_OVF_BIT]) r_ovf <= 1'b0;
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_div_lat <= 16'd1;
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state   <= START;
            r_shift   <= w_head;
            r_tx      <= 1'b0;
            r_div_lat <= w_div_eff;
            r_baud    <= w_div_eff - 16'd1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= 3'd0;
            r_baud    <= r_div_lat - 16'd1;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= r_div_lat - 16'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_state   <= START;
              r_shift   <= w_head;
              r_tx      <= 1'b0;
              r_div_lat <= w_div_eff;
              r_baud    <= w_div_eff - 16'd1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
      endcase
    end
  end

  // STATUS word and read-data mux (zero outside the window)
  always_comb begin
    w_stat = 32'd0;
    w_stat[STAT_BUSY_BIT]  = (r_state != IDLE);
    w_stat[STAT_FULL_BIT]  = w_full;
    w_stat[STAT_EMPTY_BIT] = w_empty;
    w_stat[STAT_OVF_BIT]   = r_ovf;
    w_stat[STAT_CNT_LSB +: CNT_W] = w_count;
    w_rdata = 32'd0;
    if (w_sel_stat)     w_rdata = w_stat;
    else if (w_sel_div) w_rdata = {16'd0, r_div};
  end
  assign u_bus.rdata = w_rdata;
  assign TX = r_tx;

`ifdef OTTER_UART_TX_IRQ_EN
  logic r_irq;
  // One-cycle pulse when the last queued frame finishes and the FSM idles
  always_ff @(posedge CLK) begin
    if (RESET) r_irq <= 1'b0;
    else       r_irq <= (r_state == STOP) & w_bit_end & w_empty;
  end
  assign IRQ = r_irq;
`else
  assign IRQ = 1'b0;
`endif
endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Directed bench for otter_iobus_uart_tx: register map, 8N1 framing,
// back-to-back frames, overflow, mid-frame reset and divisor latching.
module tb_otter_iobus_uart_tx;
  localparam logic [31:0] BASE = 32'h1100_0200;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
`ifdef OTTER_UART_TX_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  int   irq_cnt = 0;
  logic [15:0] cur_div = 16'd434;
  logic [23:0] exp_q[$];

  otter_iobus_uart_tx_if bus ();

  otter_iobus_uart_tx dut (
    .CLK        (clk),
    .RESET      (rst),
    .IOBUS_ADDR (bus.addr),
    .IOBUS_OUT  (bus.wdata),
    .IOBUS_WR   (bus.wr),
    .IOBUS_IN   (bus.rdata),
    .TX         (tx),
    .IRQ        (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.wr = 1'b1;
    @(posedge clk);
    #1 bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.wr = 1'b0;
    #1 d = bus.rdata;
  endtask

  task automatic set_div(input logic [15:0] d);
    cur_div = d;
    bus_write(A_DIV, {16'd0, d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back({cur_div, b});
    bus_write(A_DATA, {24'd0, b});
  endtask

  // scoreboard: pop expected {divisor, byte}, sample the frame cycle by cycle
  task automatic rx_frame(input int exp_gap);
    logic [23:0] e;
    logic [7:0]  ob;
    logic        eb;
    int gap, bad, div;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    gap = 0;
    while (gap < 2000) begin
      @(negedge clk);
      if (tx === 1'b0) break;
      gap++;
    end
    check("start_gap", gap, exp_gap);
    if (gap >= 2000) return;
    div = int'(e[23:8]);
    bad = 0; ob = 8'd0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < div; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b-1];
        if (tx !== eb) bad++;
        if (c == 0 && b >= 1 && b <= 8) ob[b-1] = tx;
      end
    end
    check("frame_byte", {24'd0, ob}, {24'd0, e[7:0]});
    check("frame_shape", bad, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int base_irq, edges;
    logic prev;
    bus.addr = 32'd0; bus.wdata = 32'd0; bus.wr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state and register map
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(A_STAT, rd); check("rst_status", rd, 32'h4);
    bus_read(A_DIV, rd);  check("rst_div", rd, 32'd434);
    bus_read(A_DATA, rd); check("data_read0", rd, 32'd0);
    bus_read(BASE + 32'hC, rd); check("ofs_c_read0", rd, 32'd0);
    bus_write(A_DIV, 32'h0001_0007);
    bus_read(A_DIV, rd);  check("div_upper_ignored", rd, 32'd7);
    bus_write(BASE + 32'h100, 32'h0000_0033);
    bus_read(A_DIV, rd);  check("far_wr_div", rd, 32'd7);
    bus_read(A_STAT, rd); check("far_wr_stat", rd, 32'h4);
    bus_read(BASE + 32'h100, rd); check("far_read0", rd, 32'd0);

    // single 0x55 frame at 4 cycles/bit
    set_div(16'd4);
    base_irq = irq_cnt;
    send_byte(8'h55);
    bus_read(A_STAT, rd); check("queued_status", rd, 32'h100);
    rx_frame(0);
    bus_read(A_STAT, rd); check("idle_after_stop", rd, 32'h4);
    repeat (2) @(negedge clk);
    check("irq_single", irq_cnt - base_irq, IRQ_EXP);

    // back-to-back frames, no idle gap
    base_irq = irq_cnt;
    send_byte(8'hA5);
    send_byte(8'h3C);
    rx_frame(0);
    rx_frame(0);
    repeat (3) @(negedge clk);
    check("irq_b2b", irq_cnt - base_irq, IRQ_EXP);

    // divisor change mid-frame only affects the next frame
    base_irq = irq_cnt;
    set_div(16'd2);
    send_byte(8'h81);
    send_byte(8'h7E);
    fork
      rx_frame(0);
      begin
        cur_div = 16'd6;
        bus_write(A_DIV, 32'd6);
      end
    join
    exp_q[0][23:8] = 16'd6;
    rx_frame(0);
    repeat (3) @(negedge clk);
    check("irq_divchg", irq_cnt - base_irq, IRQ_EXP);

    // overflow: 10 writes into an 8-deep FIFO with a slow divisor
    set_div(16'd100);
    for (int i = 0; i < 10; i++) bus_write(A_DATA, 32'(i * 17 + 1));
    bus_read(A_STAT, rd); check("ovf_status", rd, 32'h80B);
    bus_write(A_STAT, 32'h0);
    bus_read(A_STAT, rd); check("ovf_kept", rd, 32'h80B);
    bus_write(A_STAT, 32'h8);
    bus_read(A_STAT, rd); check("ovf_cleared", rd, 32'h803);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus_read(A_STAT, rd); check("ovf_reset_status", rd, 32'h4);
    bus_read(A_DIV, rd);  check("ovf_reset_div", rd, 32'd434);

    // reset during data bit 3
    set_div(16'd4);
    bus_write(A_DATA, 32'hF0);
    edges = 0;
    while (edges < 50) begin
      @(negedge clk);
      if (tx === 1'b0) break;
      edges++;
    end
    check("mid_start_seen", 32'(edges < 50), 32'd1);
    repeat (17) @(negedge clk);
    check("mid_bit3_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    bus.addr = A_STAT; #1;
    check("mid_rst_status", bus.rdata, 32'h4);
    rst = 1'b0;
    prev = tx; edges = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== prev) edges++;
      prev = tx;
    end
    check("mid_rst_quiet", edges, 0);
    bus_read(A_DIV, rd); check("mid_rst_div", rd, 32'd434);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/otter_iobus_uart_tx.md
# otter_iobus_uart_tx

Memory-mapped UART transmitter responding to the OTTER IOBUS initiator. Decodes CPU stores on `IOBUS_ADDR`/`IOBUS_OUT`/`IOBUS_WR` into a byte FIFO and register writes. Drives status and register reads back on `IOBUS_IN`. Serialises FIFO bytes as 8N1 frames on `TX`.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `BASE_ADDR`, default 32'h1100_0200: word-aligned base of the 3-register window.
- `FIFO_DEPTH`, default 8: byte FIFO entries; power of 2, range 2..64.
- `DIV_RESET`, default 16'd434: bit period in CLK cycles after reset (50 MHz / 115200).

Ports:
- `CLK` in, 1: system clock.
- `RESET` in, 1: synchronous, active-high.
- `IOBUS_ADDR` in, 32: CPU memory-stage address.
- `IOBUS_OUT` in, 32: CPU store data.
- `IOBUS_WR` in, 1: store strobe, one cycle per store.
- `IOBUS_IN` out, 32: read data. Zero when the address is outside the window.
- `TX` out, 1: serial line, idle high.
- `IRQ` out, 1: transmit-done pulse, intended for `INTR`.

## Operation
- Register map (offset from `BASE_ADDR`):
  - +0x0 DATA. Write pushes `IOBUS_OUT[7:0]`. Reads return 0.
  - +0x4 STATUS. Read-only except bit3.
    - bit0 busy (FSM not IDLE).
    - bit1 fifo_full.
    - bit2 fifo_empty.
    - bit3 overflow (sticky). Writing 1 to bit3 clears it.
    - bits[14:8] fifo count.
  - +0x8 DIVISOR. R/W, `[15:0]`. Upper bits ignored on write, read as 0.
- Address match is on the full 32 bits. Any other offset: writes ignored, reads return 0.
- `IOBUS_IN` is a combinational mux of `IOBUS_ADDR`, so read data is valid in the same cycle the address is presented.
- FIFO push: on a DATA write when not full, or when full and a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. This pops the head into the shift register, sets TX=0 and latches the divisor (0 is treated as 1).
  - START → DATA after one bit period.
  - DATA shifts LSB first; 8 bit periods; bit index 0..7.
  - DATA → STOP after bit 7, TX=1.
  - STOP → START directly if the FIFO is non-empty (no idle gap), otherwise → IDLE.
- Bit-period counter counts latched_div-1 down to 0. A DIVISOR write mid-frame takes effect at the next frame.
- Reset (including mid-frame) takes effect at the reset edge:
  - TX=1, FSM IDLE.
  - FIFO emptied.
  - DIVISOR=`DIV_RESET`.
  - overflow=0, IRQ=0.
  - `IOBUS_IN` follows address decode of the reset state.

## Timing
- `TX` is registered.
- A DATA write sampled at edge k, with FSM IDLE and FIFO empty: FIFO count becomes 1 after k. TX goes low after edge k+1. busy=1 from k+1.
- Frame length is exactly 10×latched_div cycles from the TX falling edge to the end of the stop bit.
- Back-to-back frames: the START of the next frame begins on the edge that ends STOP.
- STATUS reflects state as of the last edge. A write and a read of the same register cannot occur in one cycle.
- Count and flags update on the edge after the push or pop.

## Configuration
- `OTTER_UART_TX_IRQ_EN` defined: `IRQ` is a one-cycle pulse on the edge the FSM enters IDLE from STOP with the FIFO empty.
- Undefined: `IRQ` is tied to 0, and no IRQ logic is generated.
- Register map is identical in both builds.

## Structure
- Shared package `otter_io_pkg`:
  - register offset constants `UART_DATA_OFS`, `UART_STAT_OFS`, `UART_DIV_OFS`.
  - `uart_tx_state_t` enum {IDLE, START, DATA, STOP}.
  - STATUS bit-position constants.
- Sub-module `otter_sync_fifo` (parameterised width/depth): push, pop, full, empty, count; first-word-fall-through head output.
- Top level holds:
  - address decode.
  - read mux.
  - DIVISOR/overflow registers.
  - FSM, bit counter, baud counter, shift register.

## Test plan
- DIVISOR=4, write DATA=0x55:
  - TX low 4 cycles.
  - then 1,0,1,0,1,0,1,0 at 4 cycles each.
  - then high 4 cycles.
  - frame is 40 cycles.
  - busy drops after the stop bit.
- Write 0xA5 then 0x3C on consecutive cycles:
  - two frames with no idle cycle between the stop bit and the next start bit.
  - with `OTTER_UART_TX_IRQ_EN`, exactly one IRQ pulse, after the second frame.
- FIFO_DEPTH=8, DIVISOR=100, write 10 bytes in 10 consecutive cycles:
  - first byte popped at cycle 1 so 9 bytes fit.
  - 10th dropped, overflow=1, count=8.
  - writing STATUS with bit3=1 clears overflow.
- Reads:
  - DIVISOR after reset = 434.
  - write 0x0001_0007, read back 7.
  - read `BASE_ADDR`+0xC returns 0.
  - write with address `BASE_ADDR`+0x100 changes nothing.
- Assert RESET during bit 3 of a frame:
  - next cycle TX=1, busy=0, count=0.
  - no further TX edges for 50 cycles.
- Write to DIVISOR (2→6) during a frame at DIVISOR=2:
  - current frame completes at 2 cycles/bit.
  - next queued frame uses 6 cycles/bit.
